imm_ext_pipe: RTL
=================

Name: imm_ext_pipe

Overview:
- Parametrised, registered immediate extender for the MIPS datapath; successor to the combinational sign extender.
- Adds four extension modes, a valid/ready handshake, one-cycle registered latency and an optional skid buffer for full throughput under backpressure.
- Sits between instruction decode and the ALU B-operand mux / branch-target adder.

Parameters:
- N_IN, 16, immediate input width.
- N_OUT, 32, extended output width; constraint N_OUT >= N_IN + BR_SHIFT.
- BR_SHIFT, 2, left shift applied in branch-offset mode.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  immed/mode valid this cycle
- in_ready  output  1  block accepts input this cycle
- immed  input  N_IN  raw immediate field
- mode  input  2  00 sign, 01 zero, 10 upper, 11 branch offset
- out_valid  output  1  out holds a valid result
- out_ready  input  1  consumer accepts out this cycle
- out  output  N_OUT  extended value
- out_neg  output  1  out[N_OUT-1], registered with out

Behaviour:
- Reset: out_valid=0, out=0, out_neg=0, skid empty; in_ready=1 in the cycle after rst deasserts. rst overrides any simultaneous handshake.
- Transfer rules: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready. Latency is exactly 1 cycle from input transfer to out_valid=1 when no stall is present.
- Mode 00 (sign): out = {(N_OUT-N_IN){immed[N_IN-1]}, immed}.
- Mode 01 (zero): out = {(N_OUT-N_IN){1'b0}, immed}.
- Mode 10 (upper): out = {immed, (N_OUT-N_IN){1'b0}}.
- Mode 11 (branch): sign-extend as in mode 00, then shift left by BR_SHIFT, keeping the low N_OUT bits; vacated LSBs are 0.
- out_neg always equals out[N_OUT-1] of the presented word.
- Output stage holds out/out_neg stable while out_valid&&!out_ready. It never drops, duplicates or reorders words.
- Output register loads when empty, or when it transfers in the same cycle.
- Simultaneous input and output transfer in the same cycle: the new word replaces the old one, and out_valid stays 1.
- Output register empties (out_valid->0) on an output transfer with no new word available.
- Illegal parameter sets (N_OUT < N_IN + BR_SHIFT) must fail elaboration via a generate-time check.

Optional Feature:
- Macro: IMM_EXT_SKID_EN.
- Defined:
  - A one-entry skid register behind the output stage; in_ready is driven directly from a flop, with no combinational path from out_ready.
  - in_ready = !skid_full.
  - If an input transfers while the output stage is stalled, the computed word goes to the skid and skid_full=1.
  - When the output transfers, the skid word moves to the output stage next cycle, and skid_full clears.
  - Sustains 1 word/cycle with a registered in_ready.
- Undefined:
  - No skid; in_ready = !out_valid || out_ready (combinational).
  - Throughput and ordering are identical to the defined case.

Test Plan:
- Reset then mode 00, immed 16'h8004, out_ready=1 -> next cycle out_valid=1, out=32'hFFFF8004, out_neg=1; then mode 00, 16'h7FFF -> 32'h00007FFF, out_neg=0.
- Mode 01, 16'h8004 -> 32'h00008004, out_neg=0; mode 10, 16'h1234 -> 32'h12340000.
- Mode 11, 16'hFFFF -> 32'hFFFFFFFC, out_neg=1; mode 11, 16'h0003 -> 32'h0000000C.
- Back-to-back stream of 4 words (16'h0001..16'h0004, mode 00) with out_ready low for 3 cycles mid-stream -> all 4 appear in order with no loss or duplicate; out is held stable while stalled; in_ready deasserts per the active build (skid/no-skid).
- Continuous in_valid=1 and out_ready=1 for 8 cycles -> 8 outputs on 8 consecutive cycles after the 1-cycle latency, in both builds.
- Assert rst while out_valid=1 and the skid is full -> next cycle out_valid=0, out=0, out_neg=0; the first post-reset input appears after 1 cycle with the correct value.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender (sign / zero / upper / branch-offset) with a valid/ready handshake.
// Define IMM_EXT_SKID_EN to add a one-entry skid register so that in_ready comes straight from a flop.
module imm_ext_pipe #(
    parameter int N_IN     = 16,
    parameter int N_OUT    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   immed,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  out,
    output logic              out_neg
);

    generate
        if (N_OUT < N_IN + BR_SHIFT) begin : g_param_check
            $error("imm_ext_pipe: N_OUT must be >= N_IN + BR_SHIFT");
        end
    endgenerate

    logic [N_OUT-1:0] sext_val;
    logic [N_OUT-1:0] ext_val;
    logic             in_xfer;
    logic             out_free;

    always_comb begin
        sext_val = {{(N_OUT-N_IN){immed[N_IN-1]}}, immed};
        ext_val  = sext_val;
        case (mode)
            2'b00:   ext_val = sext_val;
            2'b01:   ext_val = {{(N_OUT-N_IN){1'b0}}, immed};
            2'b10:   ext_val = {immed, {(N_OUT-N_IN){1'b0}}};
            default: ext_val = sext_val << BR_SHIFT;
        endcase
    end

    assign in_xfer  = in_valid && in_ready;
    // The output register may take a new word when it is empty or is handing its word over this cycle.
    assign out_free = !out_valid || out_ready;

`ifdef IMM_EXT_SKID_EN
    logic             skid_full;
    logic [N_OUT-1:0] skid_data;

    assign in_ready = !skid_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_neg   <= 1'b0;
            skid_full <= 1'b0;
            skid_data <= '0;
        end else if (out_free) begin
            // in_ready is low while the skid is full, so no new word can arrive alongside the drain.
            if (skid_full) begin
                out       <= skid_data;
                out_neg   <= skid_data[N_OUT-1];
                out_valid <= 1'b1;
                skid_full <= 1'b0;
            end else if (in_xfer) begin
                out       <= ext_val;
                out_neg   <= ext_val[N_OUT-1];
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_data <= ext_val;
            skid_full <= 1'b1;
        end
    end
`else
    assign in_ready = out_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_neg   <= 1'b0;
        end else if (out_free) begin
            if (in_xfer) begin
                out       <= ext_val;
                out_neg   <= ext_val[N_OUT-1];
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
`endif

endmodule
